cc_ubicacion_ctrl: RTL and testbench

CC_UBICACION_CTRL -- requirements
Module: cc_ubicacion_ctrl

---
 rtl/cc_ubicacion_ctrl.sv | 124 ++++++++++++
 tb/tb_cc_ubicacion_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cc_ubicacion_ctrl.sv
// One-hot position controller with button edge detection, load, end-of-vector pulse and blink FSM.
// Optional macro CC_UBICACION_CTRL_WRAP_EN makes steps past either end wrap instead of saturate.
module cc_ubicacion_ctrl #(
  parameter int UBICACION_WIDTH  = 8,
  parameter int BLINK_COUNTWIDTH = 24,
  parameter int BLINK_HALFPERIOD = 12500000
) (
  input  logic                       CC_UBICACION_CTRL_CLOCK_50,
  input  logic                       CC_UBICACION_CTRL_RESET_InHigh,
  input  logic                       CC_UBICACION_CTRL_left_In,
  input  logic                       CC_UBICACION_CTRL_right_In,
  input  logic                       CC_UBICACION_CTRL_load_In,
  input  logic [UBICACION_WIDTH-1:0] CC_UBICACION_CTRL_loadpos_InBUS,
  input  logic                       CC_UBICACION_CTRL_blink_In,
  output logic [UBICACION_WIDTH-1:0] CC_UBICACION_CTRL_UBICACION_OutBUS,
  output logic                       CC_UBICACION_CTRL_select_Out,
  output logic                       CC_UBICACION_CTRL_edge_Out
);

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } blink_state_e;

  localparam logic [UBICACION_WIDTH-1:0]  POS_LSB   = UBICACION_WIDTH'(1);
  localparam logic [UBICACION_WIDTH-1:0]  POS_MSB   = {1'b1, {(UBICACION_WIDTH-1){1'b0}}};
  localparam logic [BLINK_COUNTWIDTH-1:0] HALF_LAST = BLINK_COUNTWIDTH'(BLINK_HALFPERIOD - 1);

`ifdef CC_UBICACION_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [UBICACION_WIDTH-1:0]  pos_q, pos_d;
  logic [BLINK_COUNTWIDTH-1:0] cnt_q, cnt_d;
  blink_state_e                state_q, state_d;
  logic                        edge_q, edge_d;
  logic                        prev_left_q, prev_left_d;
  logic                        prev_right_q, prev_right_d;

  logic left_req, right_req, load_valid, moved;

  // Rising-edge requests; both together cancel, so only an exclusive request steps.
  always_comb begin
    left_req     = CC_UBICACION_CTRL_left_In & ~prev_left_q;
    right_req    = CC_UBICACION_CTRL_right_In & ~prev_right_q;
    prev_left_d  = CC_UBICACION_CTRL_left_In;
    prev_right_d = CC_UBICACION_CTRL_right_In;
    load_valid   = CC_UBICACION_CTRL_load_In
                   && (CC_UBICACION_CTRL_loadpos_InBUS != '0)
                   && ((CC_UBICACION_CTRL_loadpos_InBUS
                        & (CC_UBICACION_CTRL_loadpos_InBUS - UBICACION_WIDTH'(1))) == '0);
  end

  always_comb begin
    pos_d  = pos_q;
    edge_d = 1'b0;
    moved  = 1'b0;
    if (load_valid) begin
      pos_d = CC_UBICACION_CTRL_loadpos_InBUS;
    end else if (left_req && !right_req) begin
      if (pos_q[UBICACION_WIDTH-1]) begin
        edge_d = 1'b1;
        if (WRAP) begin
          pos_d = POS_LSB;
          moved = 1'b1;
        end
      end else begin
        pos_d = pos_q << 1;
        moved = 1'b1;
      end
    end else if (right_req && !left_req) begin
      if (pos_q[0]) begin
        edge_d = 1'b1;
        if (WRAP) begin
          pos_d = POS_MSB;
          moved = 1'b1;
        end
      end else begin
        pos_d = pos_q >> 1;
        moved = 1'b1;
      end
    end
  end

  // Blink FSM: a saturated step is not a move, so it leaves the blink phase alone.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!CC_UBICACION_CTRL_blink_In || moved || load_valid) begin
      state_d = SHOW;
      cnt_d   = '0;
    end else if (cnt_q == HALF_LAST) begin
      cnt_d   = '0;
      state_d = (state_q == SHOW) ? BLANK : SHOW;
    end else begin
      cnt_d = cnt_q + BLINK_COUNTWIDTH'(1);
    end
  end

  always_ff @(posedge CC_UBICACION_CTRL_CLOCK_50) begin
    if (CC_UBICACION_CTRL_RESET_InHigh) begin
      pos_q        <= POS_LSB;
      cnt_q        <= '0;
      state_q      <= SHOW;
      edge_q       <= 1'b0;
      prev_left_q  <= 1'b1;
      prev_right_q <= 1'b1;
    end else begin
      pos_q        <= pos_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      edge_q       <= edge_d;
      prev_left_q  <= prev_left_d;
      prev_right_q <= prev_right_d;
    end
  end

  assign CC_UBICACION_CTRL_UBICACION_OutBUS = pos_q;
  assign CC_UBICACION_CTRL_select_Out       = (state_q == BLANK);
  assign CC_UBICACION_CTRL_edge_Out         = edge_q;

endmodule

// File: tb/tb_cc_ubicacion_ctrl.sv
// Directed scoreboard bench for cc_ubicacion_ctrl (short blink half-period of 4 clocks).
module tb_cc_ubicacion_ctrl;

  localparam int W = 8;

`ifdef CC_UBICACION_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] pos;
    logic         sel;
    logic         edg;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, left_in, right_in, load_in, blink_in;
  logic [W-1:0] loadpos;
  logic [W-1:0] pos_out;
  logic         sel_out, edge_out;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  cc_ubicacion_ctrl #(
    .UBICACION_WIDTH (W),
    .BLINK_COUNTWIDTH(4),
    .BLINK_HALFPERIOD(4)
  ) dut (
    .CC_UBICACION_CTRL_CLOCK_50        (clk),
    .CC_UBICACION_CTRL_RESET_InHigh    (rst),
    .CC_UBICACION_CTRL_left_In         (left_in),
    .CC_UBICACION_CTRL_right_In        (right_in),
    .CC_UBICACION_CTRL_load_In         (load_in),
    .CC_UBICACION_CTRL_loadpos_InBUS   (loadpos),
    .CC_UBICACION_CTRL_blink_In        (blink_in),
    .CC_UBICACION_CTRL_UBICACION_OutBUS(pos_out),
    .CC_UBICACION_CTRL_select_Out      (sel_out),
    .CC_UBICACION_CTRL_edge_Out        (edge_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput();
    exp_t e;
    compared++;
    assert (sb.size() != 0) else begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      compared += 2;
      assert (pos_out === e.pos) else begin
        mismatched++;
        $error("[TB] FAIL %s.pos observed=%h expected=%h", e.tag, pos_out, e.pos);
      end
      assert (sel_out === e.sel) else begin
        mismatched++;
        $error("[TB] FAIL %s.sel observed=%b expected=%b", e.tag, sel_out, e.sel);
      end
      assert (edge_out === e.edg) else begin
        mismatched++;
        $error("[TB] FAIL %s.edge observed=%b expected=%b", e.tag, edge_out, e.edg);
      end
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the next rising edge, then check.
  task automatic applyStimulus(input bit r, input bit l, input bit rt, input bit ld,
                               input logic [W-1:0] lp, input bit bl,
                               input logic [W-1:0] ep, input bit es, input bit ee,
                               input string tag);
    exp_t e;
    rst      = r;
    left_in  = l;
    right_in = rt;
    load_in  = ld;
    loadpos  = lp;
    blink_in = bl;
    e.pos = ep;
    e.sel = es;
    e.edg = ee;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    // Reset with left held high across release: no step.
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 8'h01, 0, 0, "reset0");
    applyStimulus(1, 1, 0, 0, 8'h00, 1, 8'h01, 0, 0, "reset1");
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 8'h01, 0, 0, "held_release");
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'h01, 0, 0, "left_low");

    // Three left edges.
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 8'h02, 0, 0, "left1");
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'h02, 0, 0, "left1_low");
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 8'h04, 0, 0, "left2");
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 8'h04, 0, 0, "left2_held");
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'h04, 0, 0, "left2_low");
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 8'h08, 0, 0, "left3");
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'h08, 0, 0, "left3_low");

    // Invalid load ignored; valid load beats a simultaneous left edge.
    applyStimulus(0, 0, 0, 1, 8'h24, 0, 8'h08, 0, 0, "load_multi");
    applyStimulus(0, 1, 0, 1, 8'h20, 0, 8'h20, 0, 0, "load_wins");
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'h20, 0, 0, "load_idle");

    // Simultaneous left/right cancel.
    applyStimulus(0, 0, 0, 1, 8'h10, 0, 8'h10, 0, 0, "load_10");
    applyStimulus(0, 1, 1, 0, 8'h00, 0, 8'h10, 0, 0, "cancel");
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'h10, 0, 0, "cancel_low");
    applyStimulus(0, 0, 1, 0, 8'h00, 0, 8'h08, 0, 0, "right1");
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'h08, 0, 0, "right1_low");

    // Ends of the vector.
    applyStimulus(0, 0, 0, 1, 8'h80, 0, 8'h80, 0, 0, "load_80");
    applyStimulus(0, 1, 0, 0, 8'h00, 0, WRAP ? 8'h01 : 8'h80, 0, 1, "left_at_msb");
    applyStimulus(0, 0, 0, 0, 8'h00, 0, WRAP ? 8'h01 : 8'h80, 0, 0, "edge_one_cycle");
    applyStimulus(0, 0, 0, 1, 8'h01, 0, 8'h01, 0, 0, "load_01");
    applyStimulus(0, 0, 1, 0, 8'h00, 0, WRAP ? 8'h80 : 8'h01, 0, 1, "right_at_lsb");
    applyStimulus(0, 0, 0, 0, 8'h00, 0, WRAP ? 8'h80 : 8'h01, 0, 0, "right_lsb_low");

    // Zero-bit load is invalid and does not block a step.
    applyStimulus(0, 0, 0, 1, 8'h04, 0, 8'h04, 0, 0, "load_04");
    applyStimulus(0, 0, 1, 1, 8'h00, 0, 8'h02, 0, 0, "load_zero_step");
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'h02, 0, 0, "load_zero_low");

    // Blink: half-period of 4 clocks, then a right edge mid-BLANK forces SHOW.
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 8'h02, 0, 0, "blink_c1");
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 8'h02, 0, 0, "blink_c2");
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 8'h02, 0, 0, "blink_c3");
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 8'h02, 1, 0, "blink_c4");
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 8'h02, 1, 0, "blink_c5");
    applyStimulus(0, 0, 1, 0, 8'h00, 1, 8'h01, 0, 0, "blink_move");
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, "blink_after_move");

    // End step during blink: a wrap restarts the half-period, a saturation does not.
    applyStimulus(0, 0, 1, 0, 8'h00, 1, WRAP ? 8'h80 : 8'h01, 0, 1, "blink_end_step");
    applyStimulus(0, 0, 0, 0, 8'h00, 1, WRAP ? 8'h80 : 8'h01, 0, 0, "blink_end_n1");
    applyStimulus(0, 0, 0, 0, 8'h00, 1, WRAP ? 8'h80 : 8'h01, WRAP ? 1'b0 : 1'b1, 0, "blink_end_n2");

    // blink_In low forces SHOW; reset mid-blink restores the reset state.
    applyStimulus(0, 0, 0, 0, 8'h00, 0, WRAP ? 8'h80 : 8'h01, 0, 0, "blink_off");
    applyStimulus(0, 0, 0, 0, 8'h00, 1, WRAP ? 8'h80 : 8'h01, 0, 0, "blink_on");
    applyStimulus(1, 1, 1, 1, 8'h40, 1, 8'h01, 0, 0, "reset_mid");
    applyStimulus(0, 1, 1, 0, 8'h00, 0, 8'h01, 0, 0, "reset_held_btns");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
